// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among REQUESTERS clients.
// Define SRAM_ARB_INIT_EN to clear the whole SRAM with a write sweep after reset.
module sram_rr_arbiter #(
    parameter int REQUESTERS = 2,
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [REQUESTERS-1:0] i_req_valid,
    input  logic [REQUESTERS-1:0] i_req_w_e,
    input  logic [AW-1:0]         i_req_addr   [REQUESTERS],
    input  logic [WIDTH-1:0]      i_req_w_data [REQUESTERS],
    output logic [REQUESTERS-1:0] o_req_ready,
    output logic [REQUESTERS-1:0] o_rsp_valid,
    output logic [WIDTH-1:0]      o_rsp_data,
    output logic                  o_sram_e,
    output logic                  o_sram_w_e,
    output logic [AW-1:0]         o_sram_addr,
    output logic [WIDTH-1:0]      o_sram_w_data,
    input  logic [WIDTH-1:0]      i_sram_r_data,
    output logic                  o_busy
);

    localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [REQUESTERS-1:0] rsp_pend_q, rsp_pend_d;
    logic [REQUESTERS-1:0] grant_oh;
    logic [PW-1:0]         grant_idx;
    logic                  grant_found;
    logic                  run;
    logic                  xfer;

`ifdef SRAM_ARB_INIT_EN
    typedef enum logic {INIT, RUN} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] init_cnt_q, init_cnt_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == INIT) begin
            init_cnt_d = init_cnt_q + AW'(1);
            if (init_cnt_q == AW'(DEPTH - 1)) begin
                state_d = RUN;
            end
        end
    end

    assign run    = (state_q == RUN);
    assign o_busy = ~run;
`else
    assign run    = 1'b1;
    assign o_busy = 1'b0;
`endif

    // First pass covers rr_ptr..REQUESTERS-1, second pass wraps around to 0.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            if (!grant_found && i_req_valid[k] && (k >= int'(rr_ptr_q))) begin
                grant_found = 1'b1;
                grant_idx   = PW'(k);
                grant_oh[k] = 1'b1;
            end
        end
        for (int k = 0; k < REQUESTERS; k++) begin
            if (!grant_found && i_req_valid[k]) begin
                grant_found = 1'b1;
                grant_idx   = PW'(k);
                grant_oh[k] = 1'b1;
            end
        end
    end

    assign xfer        = run & grant_found;
    assign o_req_ready = run ? grant_oh : '0;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        rsp_pend_d = '0;
        if (xfer) begin
            rr_ptr_d = (grant_idx == PW'(REQUESTERS - 1)) ? '0 : grant_idx + PW'(1);
            if (!i_req_w_e[grant_idx]) begin
                rsp_pend_d = grant_oh;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr_q   <= '0;
            rsp_pend_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rsp_pend_q <= rsp_pend_d;
        end
    end

    always_comb begin
        o_sram_e      = xfer;
        o_sram_w_e    = xfer & i_req_w_e[grant_idx];
        o_sram_addr   = i_req_addr[grant_idx];
        o_sram_w_data = i_req_w_data[grant_idx];
`ifdef SRAM_ARB_INIT_EN
        if (!run) begin
            o_sram_e      = 1'b1;
            o_sram_w_e    = 1'b1;
            o_sram_addr   = init_cnt_q;
            o_sram_w_data = '0;
        end
`endif
    end

    assign o_rsp_valid = rsp_pend_q;
    assign o_rsp_data  = i_sram_r_data;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter with a behavioural SRAM and a response scoreboard.
// Covers both builds; the INIT sweep checks are active when SRAM_ARB_INIT_EN is defined.
module tb_sram_rr_arbiter;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] data;
    } rspT;

    logic        clk;
    logic        rst;
    logic [1:0]  reqValid;
    logic [1:0]  reqWe;
    logic [2:0]  reqAddr  [2];
    logic [31:0] reqWData [2];
    logic [1:0]  reqReady;
    logic [1:0]  rspValid;
    logic [31:0] rspData;
    logic        sramE;
    logic        sramWe;
    logic [2:0]  sramAddr;
    logic [31:0] sramWData;
    logic [31:0] sramRData;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] sramMem [8] = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003,
                                 32'hC0DE0004, 32'hC0DE0005, 32'hC0DE0006, 32'hC0DE0007};
    logic [31:0] shadowMem [8] = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003,
                                   32'hC0DE0004, 32'hC0DE0005, 32'hC0DE0006, 32'hC0DE0007};
    rspT expQ [$];

    sram_rr_arbiter #(
        .REQUESTERS(2),
        .WIDTH(32),
        .DEPTH(8)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_req_valid(reqValid),
        .i_req_w_e(reqWe),
        .i_req_addr(reqAddr),
        .i_req_w_data(reqWData),
        .o_req_ready(reqReady),
        .o_rsp_valid(rspValid),
        .o_rsp_data(rspData),
        .o_sram_e(sramE),
        .o_sram_w_e(sramWe),
        .o_sram_addr(sramAddr),
        .o_sram_w_data(sramWData),
        .i_sram_r_data(sramRData),
        .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM: read data appears the cycle after an enabled read.
    always @(posedge clk) begin
        if (sramE) begin
            if (sramWe) sramMem[sramAddr] <= sramWData;
            else        sramRData <= sramMem[sramAddr];
        end
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] we,
                                 input logic [2:0] a0, input logic [2:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1);
        reqValid    = valid;
        reqWe       = we;
        reqAddr[0]  = a0;
        reqAddr[1]  = a1;
        reqWData[0] = d0;
        reqWData[1] = d1;
    endtask

    // Checks grant and SRAM drive for this cycle, pops the response expected now,
    // then pushes the response this cycle's grant should produce next cycle.
    task automatic checkOutput(input logic [1:0] expReady);
        logic kSel;
        rspT  expRsp;
        kSel = expReady[1];
        checkValue("req_ready", 32'(reqReady), 32'(expReady));
        checkValue("busy", 32'(busy), 32'd0);
        checkValue("sram_e", 32'(sramE), 32'(|expReady));
        if (expReady != 2'b00) begin
            checkValue("sram_w_e", 32'(sramWe), 32'(reqWe[kSel]));
            checkValue("sram_addr", 32'(sramAddr), 32'(reqAddr[kSel]));
            if (reqWe[kSel]) checkValue("sram_w_data", sramWData, reqWData[kSel]);
        end else begin
            checkValue("sram_w_e_idle", 32'(sramWe), 32'd0);
        end
        if (expQ.size() > 0) expRsp = expQ.pop_front();
        else expRsp = '{valid: 2'b00, data: 32'h0};
        checkValue("rsp_valid", 32'(rspValid), 32'(expRsp.valid));
        if (expRsp.valid != 2'b00) checkValue("rsp_data", rspData, expRsp.data);
        if (expReady != 2'b00 && !reqWe[kSel]) begin
            expQ.push_back('{valid: expReady, data: shadowMem[reqAddr[kSel]]});
        end else begin
            expQ.push_back('{valid: 2'b00, data: 32'h0});
        end
        if (expReady != 2'b00 && reqWe[kSel]) shadowMem[reqAddr[kSel]] = reqWData[kSel];
    endtask

    task automatic runCycle(input logic [1:0] valid, input logic [1:0] we,
                            input logic [2:0] a0, input logic [2:0] a1,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [1:0] expReady);
        @(negedge clk);
        applyStimulus(valid, we, a0, a1, d0, d1);
        #1;
        checkOutput(expReady);
    endtask

    // Caller has just released reset; the first sweep cycle is checked immediately.
    task automatic initSweep(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            checkValue("init_busy", 32'(busy), 32'd1);
            checkValue("init_ready", 32'(reqReady), 32'd0);
            checkValue("init_sram_e", 32'(sramE), 32'd1);
            checkValue("init_sram_w_e", 32'(sramWe), 32'd1);
            checkValue("init_sram_addr", 32'(sramAddr), 32'(i));
            checkValue("init_sram_w_data", sramWData, 32'd0);
            checkValue("init_rsp_valid", 32'(rspValid), 32'd0);
        end
        if (n == 8) begin
            for (int i = 0; i < 8; i++) shadowMem[i] = 32'h0;
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(2'b00, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        checkValue("reset_rsp_valid", 32'(rspValid), 32'd0);

`ifdef SRAM_ARB_INIT_EN
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(2'b11, 2'b00, 3'd5, 3'd6, 32'h0, 32'h0);
        #1;
        initSweep(8);
        runCycle(2'b01, 2'b00, 3'd5, 3'd0, 32'h0, 32'h0, 2'b01);
`else
        @(negedge clk);
        applyStimulus(2'b01, 2'b00, 3'd5, 3'd0, 32'h0, 32'h0);
        rst = 1'b0;
        #1;
        checkOutput(2'b01);
`endif

        // rr_ptr is 1 here; a lone req1 read brings it back to 0
        runCycle(2'b10, 2'b00, 3'd0, 3'd7, 32'h0, 32'h0, 2'b10);
        for (int i = 0; i < 4; i++) begin
            runCycle(2'b11, 2'b00, 3'd1, 3'd6, 32'h0, 32'h0, (i % 2 == 0) ? 2'b01 : 2'b10);
        end

        runCycle(2'b01, 2'b01, 3'd3, 3'd0, 32'hDEADBEEF, 32'h0, 2'b01);
        runCycle(2'b10, 2'b00, 3'd0, 3'd3, 32'h0, 32'h0, 2'b10);

        runCycle(2'b10, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 2'b10);
        runCycle(2'b10, 2'b00, 3'd0, 3'd1, 32'h0, 32'h0, 2'b10);
        runCycle(2'b10, 2'b10, 3'd0, 3'd4, 32'h0, 32'h12345678, 2'b10);
        runCycle(2'b10, 2'b00, 3'd0, 3'd3, 32'h0, 32'h0, 2'b10);
        runCycle(2'b11, 2'b00, 3'd4, 3'd2, 32'h0, 32'h0, 2'b01);

        // req0 is passed over, drops out, and an idle cycle must leave rr_ptr alone
        runCycle(2'b11, 2'b00, 3'd0, 3'd4, 32'h0, 32'h0, 2'b10);
        runCycle(2'b00, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 2'b00);
        runCycle(2'b11, 2'b00, 3'd6, 3'd7, 32'h0, 32'h0, 2'b01);
        runCycle(2'b01, 2'b00, 3'd3, 3'd0, 32'h0, 32'h0, 2'b01);

        runCycle(2'b01, 2'b00, 3'd2, 3'd0, 32'h0, 32'h0, 2'b01);
        rst = 1'b1;
        applyStimulus(2'b00, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0);
        expQ.delete();
        @(negedge clk);
        #1;
        checkValue("reset_mid_read_rsp", 32'(rspValid), 32'd0);

`ifdef SRAM_ARB_INIT_EN
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(2'b11, 2'b00, 3'd1, 3'd2, 32'h0, 32'h0);
        #1;
        initSweep(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        initSweep(8);
        runCycle(2'b10, 2'b00, 3'd0, 3'd3, 32'h0, 32'h0, 2'b10);
`else
        @(negedge clk);
        applyStimulus(2'b10, 2'b00, 3'd0, 3'd3, 32'h0, 32'h0);
        rst = 1'b0;
        #1;
        checkOutput(2'b10);
`endif
        runCycle(2'b00, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 2'b00);
        runCycle(2'b00, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
